// File: rtl/quiz_pkg.sv
// rtl/quiz_pkg.sv - shared types and constants for the operator-quiz game
// Contents:
//   state_t     round sequencer states
//   OP_*        operator codes as delivered by the puzzle ROM (switch bit index)
//   seg7_digit  0..9 to active-high gfedcba segment pattern, shared with the displays
package quiz_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        ARMED    = 3'd2,
        ANSWER   = 3'd3,
        FEEDBACK = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    function automatic logic [6:0] seg7_digit(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// rtl/quiz_round_ctrl_if.sv - game-side signal bundle of the round sequencer
// Signals:
//   start, tick, switch[3:0], exp_op[1:0]          into the sequencer
//   pattern_idx, show, score, round, time_left,
//   correct, wrong, timeout, busy, game_over        out of the sequencer
// Modports: master = sequencer, slave = surrounding game logic / bench.
interface quiz_round_ctrl_if #(
    parameter int NUM_PATTERNS = 8
);
    localparam int IDX_W = $clog2(NUM_PATTERNS);

    logic             start;
    logic             tick;
    logic [3:0]       switch;
    logic [1:0]       exp_op;
    logic [IDX_W-1:0] pattern_idx;
    logic             show;
    logic [3:0]       score;
    logic [3:0]       round;
    logic [3:0]       time_left;
    logic             correct;
    logic             wrong;
    logic             timeout;
    logic             busy;
    logic             game_over;

    modport master (
        input  start, tick, switch, exp_op,
        output pattern_idx, show, score, round, time_left,
               correct, wrong, timeout, busy, game_over
    );

    modport slave (
        output start, tick, switch, exp_op,
        input  pattern_idx, show, score, round, time_left,
               correct, wrong, timeout, busy, game_over
    );

endinterface

// File: rtl/switch_sync_edge.sv
// rtl/switch_sync_edge.sv - 4-bit two-flop switch synchronizer with rising-edge pulses
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   sw_in    in   raw switches
//   sw_sync  out  synchronized switch levels
//   sw_rise  out  one-cycle pulse per bit on a synchronized 0->1 transition
module switch_sync_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_in,
    output logic [3:0] sw_sync,
    output logic [3:0] sw_rise
);

    logic [3:0] meta_q;
    logic [3:0] sync_q;
    logic [3:0] prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 4'b0;
            sync_q <= 4'b0;
            prev_q <= 4'b0;
        end else begin
            meta_q <= sw_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sw_sync = sync_q;
    assign sw_rise = sync_q & ~prev_q;

endmodule

// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - operator-quiz round sequencer: load, arm, answer window, scoring
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-low reset
//   bus    quiz_round_ctrl_if.master: start/tick/switch/exp_op in;
//          pattern_idx/show/score/round/time_left/correct/wrong/timeout/busy/game_over out
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int NUM_PATTERNS = 8,
    parameter int ROUNDS       = 8,
    parameter int ANS_TICKS    = 5,
    parameter int FB_TICKS     = 2,
    parameter int SCORE_MAX    = 9
) (
    input  logic              clk,
    input  logic              reset,
    quiz_round_ctrl_if.master bus
);

    localparam int IDX_W = $clog2(NUM_PATTERNS);

    state_t           state_q, state_n;
    logic [IDX_W-1:0] pidx_q, pidx_n;
    logic [3:0]       round_q, round_n;
    logic [3:0]       score_q, score_n;
    logic [3:0]       tleft_q, tleft_n;
    logic [3:0]       fb_q, fb_n;
    logic [1:0]       exp_q, exp_n;
    logic             load2_q, load2_n;
    logic             correct_q, correct_n;
    logic             wrong_q, wrong_n;
    logic             timeout_q, timeout_n;
    logic             start_q;
    logic             start_edge;
    logic [3:0]       sw_sync;
    logic [3:0]       sw_rise;

    switch_sync_edge u_sync (
        .clk     (clk),
        .reset   (reset),
        .sw_in   (bus.switch),
        .sw_sync (sw_sync),
        .sw_rise (sw_rise)
    );

    assign start_edge = bus.start & ~start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            pidx_q    <= '0;
            round_q   <= 4'd0;
            score_q   <= 4'd0;
            tleft_q   <= 4'd0;
            fb_q      <= 4'd0;
            exp_q     <= 2'd0;
            load2_q   <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            timeout_q <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            pidx_q    <= pidx_n;
            round_q   <= round_n;
            score_q   <= score_n;
            tleft_q   <= tleft_n;
            fb_q      <= fb_n;
            exp_q     <= exp_n;
            load2_q   <= load2_n;
            correct_q <= correct_n;
            wrong_q   <= wrong_n;
            timeout_q <= timeout_n;
            start_q   <= bus.start;
        end
    end

    always_comb begin
        state_n   = state_q;
        pidx_n    = pidx_q;
        round_n   = round_q;
        score_n   = score_q;
        tleft_n   = tleft_q;
        fb_n      = fb_q;
        exp_n     = exp_q;
        load2_n   = load2_q;
        correct_n = 1'b0;
        wrong_n   = 1'b0;
        timeout_n = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_edge) begin
                    state_n = LOAD;
                    round_n = 4'd1;
                    score_n = 4'd0;
                    pidx_n  = '0;
                    load2_n = 1'b0;
                end
            end
            LOAD: begin
                // ROM output lags pattern_idx by one cycle, so sample on the second cycle.
                if (!load2_q) begin
                    load2_n = 1'b1;
                end else begin
                    load2_n = 1'b0;
                    exp_n   = bus.exp_op;
                    state_n = ARMED;
                end
            end
            ARMED: begin
                // A switch still held from the previous round must be released first.
                if (sw_sync == 4'b0) begin
                    state_n = ANSWER;
                    tleft_n = 4'(ANS_TICKS);
                end
            end
            ANSWER: begin
                // Answer edge has priority over a coincident final tick.
                if (|sw_rise) begin
                    if (sw_sync == (4'b0001 << exp_q)) begin
                        correct_n = 1'b1;
                        if (score_q < 4'(SCORE_MAX)) begin
                            score_n = score_q + 4'd1;
                        end
                    end else begin
                        wrong_n = 1'b1;
                    end
                    state_n = FEEDBACK;
                    tleft_n = 4'd0;
                    fb_n    = 4'(FB_TICKS);
                end else if (bus.tick) begin
                    tleft_n = tleft_q - 4'd1;
                    if (tleft_q == 4'd1) begin
                        timeout_n = 1'b1;
                        state_n   = FEEDBACK;
                        fb_n      = 4'(FB_TICKS);
                    end
                end
            end
            FEEDBACK: begin
                if (bus.tick) begin
                    if (fb_q == 4'd1) begin
                        if (round_q == 4'(ROUNDS)) begin
                            state_n = DONE;
                        end else begin
                            round_n = round_q + 4'd1;
                            pidx_n  = (pidx_q == IDX_W'(NUM_PATTERNS - 1)) ? '0 : pidx_q + 1'b1;
                            load2_n = 1'b0;
                            state_n = LOAD;
                        end
                    end else begin
                        fb_n = fb_q - 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.pattern_idx = pidx_q;
    assign bus.score       = score_q;
    assign bus.round       = round_q;
    assign bus.time_left   = tleft_q;
    assign bus.correct     = correct_q;
    assign bus.wrong       = wrong_q;
    assign bus.timeout     = timeout_q;
    assign bus.show        = (state_q != IDLE) && (state_q != DONE);
    assign bus.busy        = (state_q != IDLE) && (state_q != DONE);
    assign bus.game_over   = (state_q == DONE);

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - self-checking bench for quiz_round_ctrl
module tb_quiz_round_ctrl;
    localparam int NP   = 8;
    localparam int RND  = 10;
    localparam int AT   = 5;
    localparam int FT   = 2;
    localparam int SMAX = 9;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    logic [1:0] rom [NP];
    int m_round, m_score, m_pidx;
    int tick_div = 0;

    quiz_round_ctrl_if #(.NUM_PATTERNS(NP)) bus();

    quiz_round_ctrl #(
        .NUM_PATTERNS (NP),
        .ROUNDS       (RND),
        .ANS_TICKS    (AT),
        .FB_TICKS     (FT),
        .SCORE_MAX    (SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Puzzle ROM: registered read, data one cycle after the address.
    always @(posedge clk) bus.exp_op <= rom[bus.pattern_idx];

    initial begin
        bus.tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div = (tick_div + 1) % 4;
            bus.tick = (tick_div == 0);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic logic [2:0] pulses();
        return {bus.correct, bus.wrong, bus.timeout};
    endfunction

    task automatic start_game(input bit hold);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        if (!hold) bus.start = 1'b0;
        m_round = 1;
        m_score = 0;
        m_pidx  = 0;
    endtask

    task automatic wait_answer();
        int n;
        n = 0;
        while (bus.time_left == 4'd0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 300) begin
            bad++;
            $display("FAIL answer_entry: no answer window after %0d cycles, required within 300", n);
            return;
        end
        total++;
        if (bus.time_left !== 4'(AT) || bus.round !== 4'(m_round) || bus.pattern_idx !== 3'(m_pidx)) begin
            bad++;
            $display("FAIL answer_state: time_left=%0d round=%0d pidx=%0d, required %0d %0d %0d",
                     bus.time_left, bus.round, bus.pattern_idx, AT, m_round, m_pidx);
        end
    endtask

    task automatic press(input logic [3:0] sw, input int dly);
        bit         exp_ok;
        int         lat;
        logic [2:0] pl;
        exp_ok = (sw == (4'b0001 << rom[m_pidx]));
        repeat (dly) @(negedge clk);
        bus.switch = sw;
        lat = 0;
        pl  = 3'b000;
        while (pl == 3'b000 && lat < 12) begin
            @(negedge clk);
            lat++;
            pl = pulses();
        end
        if (exp_ok && m_score < SMAX) m_score++;
        total++;
        if (pl !== (exp_ok ? 3'b100 : 3'b010)) begin
            bad++;
            $display("FAIL answer_kind sw=%b: pulses cwt=%b, required %b", sw, pl, exp_ok ? 3'b100 : 3'b010);
        end
        total++;
        if (lat != 3) begin
            bad++;
            $display("FAIL answer_latency: %0d cycles, required 3", lat);
        end
        total++;
        if (bus.score !== 4'(m_score)) begin
            bad++;
            $display("FAIL score_after_answer: %0d, required %0d", bus.score, m_score);
        end
        @(negedge clk);
        total++;
        if (pulses() !== 3'b000) begin
            bad++;
            $display("FAIL pulse_width: cwt=%b one cycle later, required 000", pulses());
        end
    endtask

    task automatic do_timeout();
        int         prev, changes, n;
        logic [2:0] pl;
        prev = AT; changes = 0; n = 0; pl = 3'b000;
        while (pl == 3'b000 && n < 200) begin
            @(negedge clk);
            n++;
            if (int'(bus.time_left) != prev) begin
                changes++;
                total++;
                if (int'(bus.time_left) != prev - 1) begin
                    bad++;
                    $display("FAIL time_left_step: %0d after %0d, required %0d", bus.time_left, prev, prev - 1);
                end
                prev = int'(bus.time_left);
            end
            pl = pulses();
        end
        total++;
        if (pl !== 3'b001 || changes != AT || bus.time_left !== 4'd0) begin
            bad++;
            $display("FAIL timeout: cwt=%b steps=%0d time_left=%0d, required 001 %0d 0", pl, changes, bus.time_left, AT);
        end
        total++;
        if (bus.score !== 4'(m_score)) begin
            bad++;
            $display("FAIL score_after_timeout: %0d, required %0d", bus.score, m_score);
        end
    endtask

    task automatic finish_round(input bit release_sw);
        logic [3:0] old_round;
        int         n;
        old_round = bus.round;
        n = 0;
        if (release_sw) bus.switch = 4'b0;
        while (!bus.game_over && bus.round == old_round && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 200) begin
            bad++;
            $display("FAIL round_advance: no progress in %0d cycles, required within 200", n);
            return;
        end
        if (m_round == RND) begin
            total++;
            if (bus.game_over !== 1'b1 || bus.busy !== 1'b0 || bus.show !== 1'b0) begin
                bad++;
                $display("FAIL game_end: game_over=%b busy=%b show=%b, required 1 0 0", bus.game_over, bus.busy, bus.show);
            end
        end else begin
            m_round++;
            m_pidx = (m_pidx + 1) % NP;
            total++;
            if (bus.round !== 4'(m_round) || bus.pattern_idx !== 3'(m_pidx) || bus.game_over !== 1'b0) begin
                bad++;
                $display("FAIL next_round: round=%0d pidx=%0d game_over=%b, required %0d %0d 0",
                         bus.round, bus.pattern_idx, bus.game_over, m_round, m_pidx);
            end
        end
    endtask

    task automatic play_random();
        int         kind;
        logic [3:0] good, sw;
        wait_answer();
        good = 4'b0001 << rom[m_pidx];
        kind = $urandom_range(0, 2);
        if (kind == 0) begin
            press(good, $urandom_range(0, 6));
        end else if (kind == 1) begin
            sw = good;
            while (sw == good) sw = 4'($urandom_range(1, 15));
            press(sw, $urandom_range(0, 6));
        end else begin
            do_timeout();
        end
        finish_round(1'b1);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.switch = 4'b0;
        #1;
        total++;
        if ({bus.show, bus.busy, bus.game_over, pulses()} !== 6'b0 ||
            {bus.score, bus.round, bus.time_left, bus.pattern_idx} !== 15'b0) begin
            bad++;
            $display("FAIL reset_outputs: score=%0d round=%0d tl=%0d pidx=%0d flags=%b, required all 0",
                     bus.score, bus.round, bus.time_left, bus.pattern_idx,
                     {bus.show, bus.busy, bus.game_over, pulses()});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.game_over !== 1'b0 || bus.round !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b game_over=%b round=%0d, required 0 0 0",
                     bus.busy, bus.game_over, bus.round);
        end
    endtask

    task automatic test_correct();
        start_game(1'b0);
        wait_answer();
        press(4'b0001, 2);
        finish_round(1'b1);
    endtask

    task automatic test_wrong();
        wait_answer();
        press(4'b0110, 0);
        finish_round(1'b1);
        wait_answer();
        press(4'b0001, 3);
        finish_round(1'b1);
    endtask

    task automatic test_timeout();
        wait_answer();
        do_timeout();
        finish_round(1'b1);
    endtask

    task automatic test_held();
        bit stall_ok;
        wait_answer();
        press(4'b0001 << rom[m_pidx], 1);
        finish_round(1'b0);
        stall_ok = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.time_left != 4'd0 || pulses() != 3'b000 || !bus.busy) stall_ok = 1'b0;
        end
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.time_left != 4'd0 || pulses() != 3'b000) stall_ok = 1'b0;
        end
        total++;
        if (!stall_ok) begin
            bad++;
            $display("FAIL held_stall: answer window opened or pulse while switch held, required stall");
        end
        total++;
        if (bus.round !== 4'(m_round) || bus.score !== 4'(m_score)) begin
            bad++;
            $display("FAIL start_while_busy: round=%0d score=%0d, required %0d %0d", bus.round, bus.score, m_round, m_score);
        end
        bus.switch = 4'b0;
        wait_answer();
        press(4'b0001 << rom[m_pidx], 2);
        finish_round(1'b1);
    endtask

    task automatic test_saturate();
        start_game(1'b1);
        for (int r = 0; r < RND; r++) begin
            wait_answer();
            press(4'b0001 << rom[m_pidx], $urandom_range(0, 5));
            finish_round(1'b1);
        end
        total++;
        if (bus.score !== 4'(SMAX) || m_score != SMAX) begin
            bad++;
            $display("FAIL score_saturate: %0d, required %0d", bus.score, SMAX);
        end
        repeat (30) @(negedge clk);
        total++;
        if (bus.game_over !== 1'b1 || bus.score !== 4'(SMAX)) begin
            bad++;
            $display("FAIL start_level_no_restart: game_over=%b score=%0d, required 1 %0d", bus.game_over, bus.score, SMAX);
        end
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        m_round = 1; m_score = 0; m_pidx = 0;
        total++;
        if (bus.round !== 4'd1 || bus.score !== 4'd0 || bus.game_over !== 1'b0 || bus.busy !== 1'b1) begin
            bad++;
            $display("FAIL restart: round=%0d score=%0d game_over=%b busy=%b, required 1 0 0 1",
                     bus.round, bus.score, bus.game_over, bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        wait_answer();
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({bus.show, bus.busy, bus.game_over, pulses()} !== 6'b0 ||
            {bus.score, bus.round, bus.time_left, bus.pattern_idx} !== 15'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs: score=%0d round=%0d tl=%0d flags=%b, required all 0",
                     bus.score, bus.round, bus.time_left, {bus.show, bus.busy, bus.game_over, pulses()});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (bus.busy !== 1'b0 || bus.show !== 1'b0 || bus.round !== 4'd0) begin
            bad++;
            $display("FAIL idle_after_mid_reset: busy=%b show=%b round=%0d, required 0 0 0", bus.busy, bus.show, bus.round);
        end
        start_game(1'b0);
        wait_answer();
    endtask

    initial begin
        rom[0] = 2'd0;
        rom[1] = 2'd2;
        rom[2] = 2'd2;
        for (int i = 3; i < NP; i++) rom[i] = 2'($urandom_range(0, 3));
        bus.start  = 1'b0;
        bus.switch = 4'b0;

        test_reset();
        test_correct();
        test_wrong();
        test_timeout();
        test_held();
        while (m_round < RND) play_random();
        play_random();
        test_saturate();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
